// File: rtl/bram_c_reader_pkg.sv
// Shared sizing and FSM encodings for the BRAM C read-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bram_c_reader_pkg;

    localparam int DWIDTH       = 8;             // bits per matrix element
    localparam int MAT_MUL_SIZE = 4;             // elements per BRAM word (one row)
    localparam int AWIDTH       = 10;            // BRAM address width
    localparam int ADDR_STRIDE  = MAT_MUL_SIZE;  // address step per row, matches the writer
    localparam int FIFO_DEPTH   = 2;             // prefetch entries; covers 1-cycle BRAM latency

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_READ  = 2'd1,
        RD_DRAIN = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry prefetch buffer with a registered head entry.
// Latency: push at end of cycle t is visible on head_data/empty in cycle t+1.
// Backpressure: push ignored when full unless popped in the same cycle; pop ignored when empty.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (flushes contents)
//   push, push_data   write one entry
//   pop               remove the head entry
//   head_data         current head entry (register output)
//   empty, full       occupancy flags
//   count             number of stored entries (0..2)
module rd_skid_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] tail_data;
    logic [1:0]       cnt;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (cnt != 2'd0);
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 2'd0;
            head_data <= '0;
            tail_data <= '0;
        end else begin
            if (do_push && do_pop) begin
                if (cnt == 2'd1) begin
                    head_data <= push_data;
                end else begin
                    head_data <= tail_data;
                    tail_data <= push_data;
                end
            end else if (do_push) begin
                if (cnt == 2'd0) begin
                    head_data <= push_data;
                end else begin
                    tail_data <= push_data;
                end
                cnt <= cnt + 2'd1;
            end else if (do_pop) begin
                head_data <= tail_data;
                cnt       <= cnt - 2'd1;
            end
        end
    end

    assign empty = (cnt == 2'd0);
    assign full  = (cnt == 2'd2);
    assign count = cnt;

endmodule

// File: rtl/bram_c_reader.sv
// Streams result rows out of BRAM C to a valid/ready consumer, in address order.
// Latency: start@T -> first bram_en@T+1 -> out_valid@T+3; 1 row/cycle sustained.
// Backpressure: out_ready low holds out_data/out_valid; reads stop when the 2-entry buffer is committed.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   start, base_addr, num_rows    transfer request, sampled only in IDLE
//   bram_addr, bram_en            BRAM C read port request
//   bram_rdata                    BRAM C read data, one cycle after bram_en
//   out_data, out_valid, out_ready  row stream to the consumer
//   busy, done                    transfer in progress / 1-cycle completion pulse
module bram_c_reader #(
    parameter int DWIDTH       = bram_c_reader_pkg::DWIDTH,
    parameter int MAT_MUL_SIZE = bram_c_reader_pkg::MAT_MUL_SIZE,
    parameter int AWIDTH       = bram_c_reader_pkg::AWIDTH,
    parameter int ADDR_STRIDE  = bram_c_reader_pkg::ADDR_STRIDE
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [AWIDTH-1:0]              base_addr,
    input  logic [7:0]                     num_rows,
    output logic [AWIDTH-1:0]              bram_addr,
    output logic                           bram_en,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done
);

    import bram_c_reader_pkg::*;

    localparam int ROW_W = MAT_MUL_SIZE * DWIDTH;

    rd_state_t  state;
    logic [7:0] num_q;
    logic [7:0] issued_cnt;
    logic [7:0] accepted_cnt;
    logic       rd_pend;       // read issued last cycle; its data is on bram_rdata now
    logic       pop;
    logic [1:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_full;
    logic [2:0] committed;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // Entries that will be occupied once this cycle's pop and pending capture settle.
    // Counting the pop lets a new read go out every cycle while the consumer keeps up;
    // without it the buffer would look full in steady state and halve throughput.
    assign committed = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, rd_pend};
    assign bram_en   = (state == RD_READ) && (committed < 3'(FIFO_DEPTH));

    rd_skid_fifo #(
        .WIDTH (ROW_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_pend),
        .push_data (bram_rdata),
        .pop       (pop),
        .head_data (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RD_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            bram_addr    <= '0;
            num_q        <= 8'd0;
            issued_cnt   <= 8'd0;
            accepted_cnt <= 8'd0;
            rd_pend      <= 1'b0;
        end else begin
            rd_pend <= bram_en;
            done    <= 1'b0;

            // bram_addr always points at the next row to fetch, so it only moves after an issue.
            if (bram_en) begin
                bram_addr  <= bram_addr + AWIDTH'(ADDR_STRIDE);
                issued_cnt <= issued_cnt + 8'd1;
            end
            if (pop) begin
                accepted_cnt <= accepted_cnt + 8'd1;
            end

            case (state)
                RD_IDLE: begin
                    if (start) begin
                        bram_addr    <= base_addr;
                        num_q        <= num_rows;
                        issued_cnt   <= 8'd0;
                        accepted_cnt <= 8'd0;
                        if (num_rows == 8'd0) begin
                            state <= RD_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RD_READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                RD_READ: begin
                    if (bram_en && (issued_cnt == num_q - 8'd1)) begin
                        state <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    // Every read has been issued, so accepting the last row implies
                    // the buffer is empty and nothing is in flight.
                    if (pop && (accepted_cnt == num_q - 8'd1)) begin
                        state <= RD_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                RD_DONE: begin
                    state <= RD_IDLE;
                end
                default: begin
                    state <= RD_IDLE;
                end
            endcase
        end
    end

    // A capture must never land on a full buffer that is not draining.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(fifo_full && rd_pend && !pop));
        end
    end

endmodule

// File: tb/tb_bram_c_reader.sv
// Directed bench for bram_c_reader with a 1-cycle registered BRAM model (mem[i] = i per element).
// Latency: n/a.
// Backpressure: out_ready driven from per-test patterns.
module tb_bram_c_reader;

    localparam int DW  = 8;
    localparam int MMS = 4;
    localparam int AW  = 10;
    localparam int RW  = MMS * DW;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          start      = 1'b0;
    logic [AW-1:0] base_addr  = '0;
    logic [7:0]    num_rows   = 8'd0;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic [RW-1:0] bram_rdata = '0;
    logic [RW-1:0] out_data;
    logic          out_valid;
    logic          out_ready  = 1'b0;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    int cur_idx, first_en, first_vld, last_vld, done_cyc, busy_n, done_n, issued, accepted;
    logic          stall_prev;
    logic [RW-1:0] data_prev;
    logic [AW-1:0] addr_q[$];
    logic [RW-1:0] data_q[$];

    always #5 clk = ~clk;

    bram_c_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .bram_addr  (bram_addr),
        .bram_en    (bram_en),
        .bram_rdata (bram_rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    // BRAM C model: registered read, each element holds the low byte of its address.
    always @(posedge clk) begin
        if (bram_en) bram_rdata <= {MMS{bram_addr[7:0]}};
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, sample once they settle.
    task automatic cyc(input logic st, input logic rdy);
        @(posedge clk);
        #1;
        start     = st;
        out_ready = rdy;
        #1;
        if (stall_prev) begin
            check_val("hold_valid", 64'(out_valid), 64'd1);
            check_val("hold_data", 64'(out_data), 64'(data_prev));
        end
        stall_prev = out_valid && !out_ready;
        data_prev  = out_data;
        if (bram_en) begin
            addr_q.push_back(bram_addr);
            issued++;
            if (first_en < 0) first_en = cur_idx;
        end
        if (out_valid) begin
            if (first_vld < 0) first_vld = cur_idx;
            last_vld = cur_idx;
        end
        if (out_valid && out_ready) begin
            data_q.push_back(out_data);
            accepted++;
        end
        if (bram_en) check_val("fifo_space", 64'(issued - accepted <= 2), 64'd1);
        if (busy) busy_n++;
        if (done) begin
            done_n++;
            if (done_cyc < 0) done_cyc = cur_idx;
        end
        cur_idx++;
    endtask

    task automatic clear_stats();
        addr_q.delete();
        data_q.delete();
        issued = 0; accepted = 0; busy_n = 0; done_n = 0;
        first_en = -1; first_vld = -1; last_vld = -1; done_cyc = -1;
        cur_idx = 0; stall_prev = 1'b0;
    endtask

    // mode 0: out_ready always 1; mode 1: ready pattern 1,0,0 repeating.
    // restart_at: cycle index at which a second start (base 0, 2 rows) is pulsed.
    task automatic run_xfer(input string tag, input int base, input int num, input int mode,
                            input int restart_at);
        logic [AW-1:0] a;
        logic [RW-1:0] e;
        clear_stats();
        base_addr = AW'(base);
        num_rows  = 8'(num);
        cyc(1'b1, 1'b1);
        while (done_cyc < 0 && cur_idx < 200) begin
            if (cur_idx == restart_at) begin
                base_addr = '0;
                num_rows  = 8'd2;
            end
            cyc(cur_idx == restart_at, (mode == 0) || (cur_idx % 3 == 0));
        end
        check_val({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        check_val({tag, "_n_addr"}, 64'(addr_q.size()), 64'(num));
        check_val({tag, "_n_rows"}, 64'(data_q.size()), 64'(num));
        check_val({tag, "_n_done"}, 64'(done_n), 64'd1);
        check_val({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        for (int k = 0; k < num; k++) begin
            a = AW'(base + k * 4);
            e = {MMS{a[7:0]}};
            if (k < addr_q.size()) check_val($sformatf("%s_addr%0d", tag, k), 64'(addr_q[k]), 64'(a));
            if (k < data_q.size()) check_val($sformatf("%s_row%0d", tag, k), 64'(data_q[k]), 64'(e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_en", 64'(bram_en), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_addr", 64'(bram_addr), 64'd0);
        check_val("rst_data", 64'(out_data), 64'd0);
        reset = 1'b0;

        // 1: basic 4-row transfer, full throughput
        run_xfer("t1", 0, 4, 0, -1);
        check_val("t1_first_en", 64'(first_en), 64'd1);
        check_val("t1_first_vld", 64'(first_vld), 64'd3);
        check_val("t1_last_vld", 64'(last_vld), 64'd6);
        check_val("t1_done_cyc", 64'(done_cyc), 64'd7);
        check_val("t1_busy_cycles", 64'(busy_n), 64'd6);

        // 2: 8 rows under backpressure
        run_xfer("t2", 0, 8, 1, -1);

        // 3: address wrap at 2^AWIDTH
        run_xfer("t3", 1016, 4, 0, -1);

        // 4: zero rows
        run_xfer("t4", 100, 0, 0, -1);
        check_val("t4_no_en", 64'(first_en == -1), 64'd1);
        check_val("t4_no_valid", 64'(first_vld == -1), 64'd1);
        check_val("t4_done_cyc", 64'(done_cyc), 64'd1);
        check_val("t4_busy", 64'(busy_n), 64'd0);

        // 5: start while busy is ignored
        run_xfer("t5", 64, 6, 0, 3);

        // 6: reset mid-transfer, then a clean restart
        clear_stats();
        base_addr = '0;
        num_rows  = 8'd8;
        cyc(1'b1, 1'b1);
        while (accepted < 2 && cur_idx < 50) cyc(1'b0, 1'b1);
        check_val("t6_two_rows", 64'(accepted), 64'd2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #2;
        check_val("t6_rst_valid", 64'(out_valid), 64'd0);
        check_val("t6_rst_en", 64'(bram_en), 64'd0);
        check_val("t6_rst_busy", 64'(busy), 64'd0);
        check_val("t6_rst_done", 64'(done), 64'd0);
        check_val("t6_rst_data", 64'(out_data), 64'd0);
        check_val("t6_rst_addr", 64'(bram_addr), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #2;
        check_val("t6_post_valid", 64'(out_valid), 64'd0);
        run_xfer("t6b", 32, 2, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
